pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central hazard and sequencing controller for the five-stage MIPS pipeline. It drives the enable/flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and generates the EX-stage forwarding selects. It also runs a small state machine for data-memory wait states and interrupt entry.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive cycles a data-memory access may wait for `mem_ready` before it is forced to complete.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_rs, id_rt  in  5  source register fields of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- id_jump  in  1  J/JAL/JR decoded in ID.
- ex_rs, ex_rt  in  5  source fields held in ID/EX.
- ex_MemRd, ex_RegWr  in  1  ID/EX control bits.
- ex_WrAddr  in  5  ID/EX destination register.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_MemRd, mem_MemWr, mem_RegWr  in  1  EX/MEM control bits.
- mem_WrAddr  in  5  EX/MEM destination register.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_RegWr  in  1  MEM/WB write enable.
- wb_WrAddr  in  5  MEM/WB destination register.
- irq  in  1  level interrupt request.
- pc_en, ifid_en, idex_en, exmem_en  out  1  register load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  load-bubble (zero controls) into the register.
- fwd_a, fwd_b  out  2  00 regfile, 01 EX/MEM ALUOut, 10 MEM/WB data.
- pc_vec  out  1  PC loads interrupt vector this cycle.
- irq_ack  out  1  one-cycle interrupt acknowledge.
- bus_err  out  1  sticky memory timeout flag.
- state  out  2  FSM state, for debug.

## Operation
- States: RUN=0, MEM_WAIT=1, IRQ_DRAIN=2.
- mem_busy = (mem_MemRd | mem_MemWr) & !mem_ready.
- Freeze (mem_busy, or MEM_WAIT with `mem_ready`=0):
  - All `*_en` outputs are 0 and all flushes are 0, except `memwb_flush`=1.
  - RUN→MEM_WAIT. The wait counter starts at 1 and increments each MEM_WAIT cycle.
  - `mem_ready`=1 releases the freeze in that same cycle and returns to the prior state, RUN or IRQ_DRAIN.
  - When the counter reaches MEM_TIMEOUT, the access is treated as ready, `bus_err` is set, and the state leaves MEM_WAIT.
- Not frozen, priority order highest first:
  1. IRQ_DRAIN:
     - `pc_en`=0, `ifid_flush`=1, `idex_flush`=1; the drain counter decrements from 2.
     - When the counter reaches 0: `pc_en`=1, `pc_vec`=1, `irq_ack`=1 for that one cycle, then →RUN.
  2. RUN with `irq`=1 and `ex_branch_taken`=0: →IRQ_DRAIN, and this cycle already applies the drain flushes.
  3. `ex_branch_taken`: `ifid_flush`=1, `idex_flush`=1; overrides any load-use stall.
  4. Load-use: `ex_MemRd` & `ex_WrAddr`≠0 & (`ex_WrAddr`==`id_rs` | (`id_uses_rt` & `ex_WrAddr`==`id_rt`)). Response: `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  5. `id_jump` and no stall: `ifid_flush`=1.
- Default: all enables 1, all flushes 0. `exmem_flush` is asserted only by reset.
- Forwarding for `fwd_a` (`ex_rs`) and `fwd_b` (`ex_rt`) independently:
  - 01 if `mem_RegWr` & `mem_WrAddr`≠0 & match.
  - Else 10 if `wb_RegWr` & `wb_WrAddr`≠0 & match.
  - Else 00.
- Register $0 never matches.

## Timing
- Reset values: state=RUN, counters 0, `bus_err`=0, all enables 0, all flushes 1, `fwd_*`=00, `pc_vec`=0, `irq_ack`=0.
- All enables, flushes and `fwd_*` are combinational from the current inputs and state, so they take effect at the next clock edge. State, counters and `bus_err` are registered.
- Load-use costs exactly one bubble. A taken branch costs two. Interrupt entry takes 3 cycles from sampling `irq` to `irq_ack`, excluding freeze cycles.
- A freeze pauses the drain counter.
- `irq` held during a freeze is taken after release.
- Reset mid-wait or mid-drain aborts to RUN on the next edge.

## Configuration
- PIPE_FORWARD_EN defined: forwarding active as above.
- PIPE_FORWARD_EN undefined:
  - `fwd_a` and `fwd_b` are tied to 00.
  - The load-use rule widens to any RAW hazard: an ID source matches `ex_WrAddr` (`ex_RegWr`) or `mem_WrAddr` (`mem_RegWr`).
  - Same stall response as load-use; the regfile is write-before-read.

## Structure
- Package `pipe_ctrl_pkg`: state enum, FWD_REG/FWD_EXMEM/FWD_MEMWB constants, DRAIN_CYCLES=2.
- Sub-module `fwd_unit`: the purely combinational forwarding compare, instantiated once.

## Test plan
- Load-use: `ex_MemRd`=1, `ex_WrAddr`=5, `id_rs`=5 → one cycle with `pc_en`=0, `ifid_en`=0, `idex_flush`=1; the next cycle all enables are 1.
- Forwarding: `mem_RegWr`=1, `mem_WrAddr`=8, `wb_WrAddr`=8, `ex_rs`=8 → `fwd_a`=01. With `ex_rt`=0 and `mem_WrAddr`=0 → `fwd_b`=00.
- Wait states: `mem_MemRd`=1 with `mem_ready` low for 3 cycles → 3 freeze cycles with `memwb_flush`=1; release on the 4th.
- Timeout: MEM_TIMEOUT=4, `mem_ready` stuck at 0 → release after 4 cycles and `bus_err`=1 until reset.
- Branch vs load-use in the same cycle: `ex_branch_taken`=1 → `ifid_flush`=`idex_flush`=1 and `pc_en`=1.
- `irq` pulse in RUN → two drain cycles, then `irq_ack`=`pc_vec`=1 for one cycle. Repeat with a 2-cycle freeze mid-drain → `irq_ack` arrives 2 cycles later.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the five-stage pipeline hazard/sequencing
//   controller: FSM state encoding, forwarding select codes, the number of
//   interrupt drain cycles and a helper that tests whether the ID-stage
//   instruction reads a given destination register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_IRQ_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int DRAIN_CYCLES = 2;

  // True when the ID instruction reads register wa; $0 never matches.
  function automatic logic reads_reg(input logic [4:0] wa,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (wa != 5'd0) && ((wa == rs) || (uses_rt && (wa == rt)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// fwd_unit
//   Purely combinational EX-stage forwarding compare.
//   Ports:
//     ex_rs, ex_rt          in   source registers of the instruction in EX
//     mem_RegWr, mem_WrAddr in   EX/MEM write enable / destination
//     wb_RegWr, wb_WrAddr   in   MEM/WB write enable / destination
//     fwd_a, fwd_b          out  select for the rs / rt operand
//   The younger result (EX/MEM) wins over MEM/WB.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_RegWr,
  input  logic [4:0] mem_WrAddr,
  input  logic       wb_RegWr,
  input  logic [4:0] wb_WrAddr,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic [4:0] src [2];
  logic [1:0] sel [2];

  assign src[0] = ex_rs;
  assign src[1] = ex_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign sel[gi] = (mem_RegWr && (mem_WrAddr != 5'd0) && (mem_WrAddr == src[gi])) ? FWD_EXMEM :
                     (wb_RegWr  && (wb_WrAddr  != 5'd0) && (wb_WrAddr  == src[gi])) ? FWD_MEMWB :
                                                                                       FWD_REG;
  end

  assign fwd_a = sel[0];
  assign fwd_b = sel[1];

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Hazard and sequencing controller for a five-stage MIPS pipeline.
//   Drives PC / pipeline-register enables and bubble flushes, EX forwarding
//   selects, and runs a small FSM for data-memory wait states (with timeout)
//   and interrupt entry (pipeline drain, then vector load).
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     id_*                       ID-stage sources / jump decode
//     ex_*                       ID/EX sources, controls, branch outcome
//     mem_*                      EX/MEM controls and data-memory ready
//     wb_*                       MEM/WB write enable / destination
//     irq                        level interrupt request
//     *_en, *_flush              register load enables / bubble inserts
//     fwd_a, fwd_b               forwarding selects
//     pc_vec, irq_ack            vector load / acknowledge (one cycle)
//     bus_err                    sticky memory timeout flag
//     state                      FSM state (debug)
//   Build option: PIPE_FORWARD_EN enables forwarding; without it the
//   forwarding selects are tied to regfile and every RAW hazard stalls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       ex_MemRd,
  input  logic       ex_RegWr,
  input  logic [4:0] ex_WrAddr,
  input  logic       ex_branch_taken,
  input  logic       mem_MemRd,
  input  logic       mem_MemWr,
  input  logic       mem_RegWr,
  input  logic [4:0] mem_WrAddr,
  input  logic       mem_ready,
  input  logic       wb_RegWr,
  input  logic [4:0] wb_WrAddr,
  input  logic       irq,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       pc_vec,
  output logic       irq_ack,
  output logic       bus_err,
  output logic [1:0] state
);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;      // state to resume after a memory wait
  state_e           run_state;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic             bus_err_q, bus_err_d;

  logic mem_busy, in_wait, timeout_hit, freeze, load_use, stall;
  logic [1:0] fwd_a_u, fwd_b_u;

  fwd_unit u_fwd (
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .mem_RegWr  (mem_RegWr),
    .mem_WrAddr (mem_WrAddr),
    .wb_RegWr   (wb_RegWr),
    .wb_WrAddr  (wb_WrAddr),
    .fwd_a      (fwd_a_u),
    .fwd_b      (fwd_b_u)
  );

  assign mem_busy    = (mem_MemRd | mem_MemWr) & ~mem_ready;
  assign in_wait     = (state_q == ST_MEM_WAIT);
  // The counter holds the number of frozen cycles so far; once it reaches
  // the limit the access is forced to complete in this cycle.
  assign timeout_hit = in_wait && (wait_cnt_q == CNT_W'(MEM_TIMEOUT));
  assign freeze      = (mem_busy | (in_wait & ~mem_ready)) & ~timeout_hit;
  // On release the pipeline behaves as the state it was frozen in.
  assign run_state   = in_wait ? ret_q : state_q;
  assign load_use    = ex_MemRd & reads_reg(ex_WrAddr, id_rs, id_rt, id_uses_rt);

`ifdef PIPE_FORWARD_EN
  assign stall = load_use;
  assign fwd_a = reset ? FWD_REG : fwd_a_u;
  assign fwd_b = reset ? FWD_REG : fwd_b_u;
  logic unused_raw;
  assign unused_raw = ex_RegWr;
`else
  // Without forwarding, wait until the producer reaches WB (regfile is
  // write-before-read).
  assign stall = load_use
               | (ex_RegWr  & reads_reg(ex_WrAddr,  id_rs, id_rt, id_uses_rt))
               | (mem_RegWr & reads_reg(mem_WrAddr, id_rs, id_rt, id_uses_rt));
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
  logic unused_raw;
  assign unused_raw = ^{fwd_a_u, fwd_b_u};
`endif

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_vec      = 1'b0;
    irq_ack     = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    bus_err_d   = bus_err_q;

    if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      if (in_wait) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end else begin
        state_d    = ST_MEM_WAIT;
        ret_d      = state_q;
        wait_cnt_d = CNT_W'(1);
      end
    end else begin
      wait_cnt_d = '0;
      state_d    = run_state;
      if (timeout_hit) bus_err_d = 1'b1;

      if (run_state == ST_IRQ_DRAIN) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (drain_cnt_q == 2'd0) begin
          pc_en   = 1'b1;
          pc_vec  = 1'b1;
          irq_ack = 1'b1;
          state_d = ST_RUN;
        end else begin
          pc_en       = 1'b0;
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end else if (irq && !ex_branch_taken) begin
        // Entry cycle already bubbles the front end.
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        state_d     = ST_IRQ_DRAIN;
        drain_cnt_d = 2'(DRAIN_CYCLES);
      end else if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (stall) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end

    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      pc_vec      = 1'b0;
      irq_ack     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= 2'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int TMO = 4;
`ifdef PIPE_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_WrAddr, mem_WrAddr, wb_WrAddr;
  logic       id_uses_rt, id_jump, ex_MemRd, ex_RegWr, ex_branch_taken;
  logic       mem_MemRd, mem_MemWr, mem_RegWr, mem_ready, wb_RegWr, irq;
  logic       pc_en, ifid_en, idex_en, exmem_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0] fwd_a, fwd_b, state;
  logic       pc_vec, irq_ack, bus_err;

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_MemRd(ex_MemRd), .ex_RegWr(ex_RegWr),
    .ex_WrAddr(ex_WrAddr), .ex_branch_taken(ex_branch_taken),
    .mem_MemRd(mem_MemRd), .mem_MemWr(mem_MemWr), .mem_RegWr(mem_RegWr),
    .mem_WrAddr(mem_WrAddr), .mem_ready(mem_ready),
    .wb_RegWr(wb_RegWr), .wb_WrAddr(wb_WrAddr), .irq(irq),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_vec(pc_vec), .irq_ack(irq_ack),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: m_wait = frozen cycles of the current access,
  // m_drain = remaining drain cycles (-1 when no interrupt is in progress).
  int  m_wait  = 0;
  int  m_drain = -1;
  bit  m_berr  = 1'b0;
  bit  e_frozen, e_timed, e_enter, e_drain;
  logic [16:0] exp_v;
  logic [16:0] obs_v;

  assign obs_v = {pc_en, ifid_en, idex_en, exmem_en,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush,
                  pc_vec, irq_ack, bus_err, state, fwd_a, fwd_b};

  function automatic bit id_reads(input logic [4:0] wa);
    return (wa != 0) && (wa == id_rs || (id_uses_rt && wa == id_rt));
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (mem_RegWr && mem_WrAddr != 0 && mem_WrAddr == src) return 2'b01;
    if (wb_RegWr && wb_WrAddr != 0 && wb_WrAddr == src)    return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit pc, ifd, idx, exm, fif, fid, fex, fwb, vec, ack, hazard;
    logic [1:0] fa, fb, st;
    pc = 1; ifd = 1; idx = 1; exm = 1;
    fif = 0; fid = 0; fex = 0; fwb = 0; vec = 0; ack = 0;
    e_drain  = (m_drain >= 0);
    e_timed  = (m_wait == TMO);
    e_frozen = (((mem_MemRd || mem_MemWr) && !mem_ready) || (m_wait > 0 && !mem_ready)) && !e_timed;
    e_enter  = 0;
    if (FWD_ON) begin
      hazard = ex_MemRd && id_reads(ex_WrAddr);
      fa = fwd_of(ex_rs);
      fb = fwd_of(ex_rt);
    end else begin
      hazard = ((ex_MemRd || ex_RegWr) && id_reads(ex_WrAddr)) || (mem_RegWr && id_reads(mem_WrAddr));
      fa = 2'b00;
      fb = 2'b00;
    end
    if (reset) begin
      pc = 0; ifd = 0; idx = 0; exm = 0; fif = 1; fid = 1; fex = 1; fwb = 1;
      fa = 2'b00; fb = 2'b00;
    end else if (e_frozen) begin
      pc = 0; ifd = 0; idx = 0; exm = 0; fwb = 1;
    end else if (e_drain) begin
      fif = 1; fid = 1;
      pc = (m_drain == 0); vec = (m_drain == 0); ack = (m_drain == 0);
    end else if (irq && !ex_branch_taken) begin
      pc = 0; fif = 1; fid = 1; e_enter = 1;
    end else if (ex_branch_taken) begin
      fif = 1; fid = 1;
    end else if (hazard) begin
      pc = 0; ifd = 0; fid = 1;
    end else if (id_jump) begin
      fif = 1;
    end
    st = (m_wait > 0) ? 2'd1 : (e_drain ? 2'd2 : 2'd0);
    exp_v = {pc, ifd, idx, exm, fif, fid, fex, fwb, vec, ack, m_berr, st, fa, fb};
  endtask

  task automatic model_update();
    if (reset) begin
      m_wait = 0; m_drain = -1; m_berr = 0;
    end else if (e_frozen) begin
      m_wait++;
    end else begin
      if (e_timed) m_berr = 1;
      m_wait = 0;
      if (e_drain)      m_drain = (m_drain == 0) ? -1 : m_drain - 1;
      else if (e_enter) m_drain = 2;
    end
  endtask

  // Compare all outputs against the model at the falling edge.
  task automatic settle(input string tag);
    @(negedge clk);
    model_eval();
    vecs++;
    assert (obs_v === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    reset = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
    ex_rs = 0; ex_rt = 0; ex_MemRd = 0; ex_RegWr = 0; ex_WrAddr = 0; ex_branch_taken = 0;
    mem_MemRd = 0; mem_MemWr = 0; mem_RegWr = 0; mem_WrAddr = 0; mem_ready = 1;
    wb_RegWr = 0; wb_WrAddr = 0; irq = 0;
  endtask

  // Pulse irq, optionally freeze for two cycles starting at cycle fz,
  // and return the number of cycles until irq_ack (bounded).
  task automatic irq_latency(input int fz, output int lat);
    idle(); irq = 1;
    settle("irq_entry");
    chk("irq_entry_pc_en", 32'(pc_en), 0);
    chk("irq_entry_flush", 32'({ifid_flush, idex_flush}), 3);
    tick();
    lat = 20;
    for (int n = 1; n < 20; n++) begin
      idle();
      if (fz > 0 && n >= fz && n < fz + 2) begin mem_MemRd = 1; mem_ready = 0; end
      else if (fz > 0 && n == fz + 2)      begin mem_MemRd = 1; mem_ready = 1; end
      settle("irq_wait");
      if (irq_ack === 1'b1) begin
        lat = n;
        chk("irq_pc_vec", 32'(pc_vec), 1);
        tick();
        break;
      end
      tick();
    end
    idle();
    settle("irq_after");
    chk("irq_ack_one_cycle", 32'(irq_ack), 0);
    tick();
  endtask

  initial begin
    int lat;
    idle();
    reset = 1;
    @(posedge clk); model_update(); #1;

    // Reset values
    settle("reset");
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_exmem_flush", 32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 4'hF);
    chk("rst_state", 32'(state), 0);
    tick();
    idle();
    settle("idle");
    chk("idle_enables", 32'({pc_en, ifid_en, idex_en, exmem_en}), 4'hF);
    tick();

    // Load-use: exactly one bubble
    idle(); ex_MemRd = 1; ex_RegWr = 1; ex_WrAddr = 5; id_rs = 5;
    settle("load_use");
    chk("lu_stall", 32'({pc_en, ifid_en, idex_flush}), 3'b001);
    tick();
    idle(); id_rs = 5;
    settle("load_use_next");
    chk("lu_release", 32'({pc_en, ifid_en, idex_en, exmem_en}), 4'hF);
    tick();

    // Forwarding
    idle(); mem_RegWr = 1; mem_WrAddr = 8; wb_RegWr = 1; wb_WrAddr = 8; ex_rs = 8; ex_rt = 0;
    settle("fwd_exmem");
    chk("fwd_a_exmem", 32'(fwd_a), FWD_ON ? 1 : 0);
    chk("fwd_b_r0", 32'(fwd_b), 0);
    tick();
    idle(); wb_RegWr = 1; wb_WrAddr = 9; ex_rt = 9; ex_rs = 8; mem_RegWr = 1; mem_WrAddr = 0;
    settle("fwd_memwb");
    chk("fwd_b_memwb", 32'(fwd_b), FWD_ON ? 2 : 0);
    chk("fwd_a_none", 32'(fwd_a), 0);
    tick();

    // Wait states: 3 freeze cycles, release on the 4th
    for (int n = 0; n < 4; n++) begin
      idle(); mem_MemRd = 1; mem_ready = (n == 3);
      settle("mem_wait");
      chk("wait_pc_en", 32'(pc_en), (n == 3) ? 1 : 0);
      chk("wait_memwb_flush", 32'(memwb_flush), (n == 3) ? 0 : 1);
      tick();
    end

    // Timeout: four freeze cycles, forced release, sticky bus_err
    for (int n = 0; n < 5; n++) begin
      idle(); mem_MemWr = 1; mem_ready = 0;
      settle("timeout");
      chk("tmo_pc_en", 32'(pc_en), (n == 4) ? 1 : 0);
      tick();
    end
    for (int n = 0; n < 3; n++) begin
      idle();
      settle("bus_err_hold");
      chk("bus_err_sticky", 32'(bus_err), 1);
      tick();
    end
    idle(); reset = 1;
    settle("bus_err_reset"); tick();
    idle();
    settle("bus_err_cleared");
    chk("bus_err_clear", 32'(bus_err), 0);
    tick();

    // Branch overrides load-use
    idle(); ex_branch_taken = 1; ex_MemRd = 1; ex_WrAddr = 5; id_rs = 5;
    settle("branch_lu");
    chk("br_flush", 32'({ifid_flush, idex_flush}), 3);
    chk("br_pc_en", 32'({pc_en, ifid_en}), 3);
    tick();

    // Interrupt entry with and without a mid-drain freeze
    irq_latency(0, lat);
    chk("irq_latency", 32'(lat), 3);
    irq_latency(1, lat);
    chk("irq_latency_freeze", 32'(lat), 5);

    // Reset mid-drain aborts to RUN
    idle(); irq = 1; settle("abort_entry"); tick();
    idle(); settle("abort_drain"); tick();
    idle(); reset = 1; settle("abort_reset"); tick();
    idle();
    settle("abort_after");
    chk("abort_state", 32'(state), 0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset           = ($urandom_range(0, 79) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_jump         = ($urandom_range(0, 7) == 0);
      ex_rs           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      ex_MemRd        = ($urandom_range(0, 3) == 0);
      ex_RegWr        = 1'($urandom_range(0, 1));
      ex_WrAddr       = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_MemRd       = ($urandom_range(0, 4) == 0);
      mem_MemWr       = ($urandom_range(0, 6) == 0);
      mem_RegWr       = 1'($urandom_range(0, 1));
      mem_WrAddr      = 5'($urandom_range(0, 3));
      mem_ready       = (n % 100 < 90) ? ($urandom_range(0, 2) != 0) : 1'b0;
      wb_RegWr        = 1'($urandom_range(0, 1));
      wb_WrAddr       = 5'($urandom_range(0, 3));
      irq             = ($urandom_range(0, 11) == 0);
      settle("random");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
